// File: rtl/core_pkg.sv
// Shared RV32I control definitions: opcodes, ALU op encodings, datapath selects, FSM states.
// MAIN_FSM_ILLEGAL_TRAP_EN adds the TRAP state to main_state_t.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RD1    = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } main_state_t;

endpackage

// File: rtl/main_fsm_opcode_class.sv
// Combinational opcode classifier: one-hot instruction class from instr[6:0].
module opcode_class
  import core_pkg::*;
(
  input  logic [6:0] op,
  output logic       is_load,
  output logic       is_store,
  output logic       is_r,
  output logic       is_i,
  output logic       is_beq,
  output logic       is_jal,
  output logic       is_illegal
);

  always_comb begin
    is_load    = (op == OP_LOAD);
    is_store   = (op == OP_STORE);
    is_r       = (op == OP_RTYPE);
    is_i       = (op == OP_ITYPE);
    is_beq     = (op == OP_BRANCH);
    is_jal     = (op == OP_JAL);
    is_illegal = !(is_load || is_store || is_r || is_i || is_beq || is_jal);
  end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle RV32I control FSM feeding alu_decoder and the datapath muxes/strobes.
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap (and flag) unsupported opcodes instead of skipping them.
module main_fsm
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_update,
  output logic             branch,
  output logic             reg_write,
  output logic             mem_write,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired,
  output main_state_t      dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  main_state_t      state;
  logic [CNT_W-1:0] retired;
  logic             is_load, is_store, is_r, is_i, is_beq, is_jal, is_illegal;

  opcode_class u_class (
    .op         (op),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_r       (is_r),
    .is_i       (is_i),
    .is_beq     (is_beq),
    .is_jal     (is_jal),
    .is_illegal (is_illegal)
  );

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  // Memory handshake: an access is issued by holding the address/strobes steady in a
  // memory state; it completes on the first rising edge where mem_ready=1, and the FSM
  // holds every output unchanged until then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      retired <= '0;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (is_illegal) begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            state     <= S_TRAP;
            illegal_q <= 1'b1;
`else
            state   <= S_FETCH;
            retired <= retired + CNT_ONE;
`endif
          end else if (is_load || is_store) state <= S_MEMADR;
          else if (is_r)                    state <= S_EXECUTER;
          else if (is_i)                    state <= S_EXECUTEI;
          else if (is_beq)                  state <= S_BEQ;
          else if (is_jal)                  state <= S_JAL;
          else                              state <= S_FETCH;
        end
        S_MEMADR:   state <= is_load ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: begin
          if (mem_ready) begin
            state   <= S_FETCH;
            retired <= retired + CNT_ONE;
          end
        end
        S_EXECUTER, S_EXECUTEI, S_JAL: state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BEQ: begin
          state   <= S_FETCH;
          retired <= retired + CNT_ONE;
        end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        S_TRAP:     state <= S_TRAP;
`endif
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; FETCH ir_write/pc_update and MEMWRITE's hold follow mem_ready.
  always_comb begin
    alu_op     = ALUOP_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALU_OUT;
    adr_src    = ADR_PC;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU_RESULT;
          ir_write   = mem_ready;
          pc_update  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD:  adr_src = ADR_RESULT;
        S_MEMWB: begin
          result_src = RES_READ_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = ADR_RESULT;
          mem_write = 1'b1;
        end
        S_EXECUTER: begin
          alu_src_a = SRCA_RD1;
          alu_op    = ALUOP_FUNCT;
        end
        S_EXECUTEI: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB:    reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = SRCA_RD1;
          alu_op    = ALUOP_SUB;
          branch    = 1'b1;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_FOUR;
          pc_update = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instr_retired = rst_n ? retired : '0;
  assign dbg_state     = rst_n ? state : S_FETCH;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  assign illegal_op    = rst_n & illegal_q;
`else
  assign illegal_op    = 1'b0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Cycle-table bench for main_fsm: each record gives inputs plus the state/counter the
// FSM must be in; expected output words are queued on drive and popped on sample.
module tb_main_fsm;
  import core_pkg::*;

  localparam int W = 51;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = '0;
  logic        mem_ready = 1'b1;
  logic [1:0]  alu_op, alu_src_a, alu_src_b, result_src;
  logic        adr_src, ir_write, pc_update, branch, reg_write, mem_write, illegal_op;
  logic [31:0] instr_retired;
  main_state_t dbg_state;

  main_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_update(pc_update), .branch(branch), .reg_write(reg_write),
    .mem_write(mem_write), .illegal_op(illegal_op),
    .instr_retired(instr_retired), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic        mr;
    main_state_t st;
    logic [31:0] cnt;
  } vec_t;

  vec_t          vecs[$];
  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            failures = 0;

  task automatic add_v(input logic r, input logic [6:0] o, input logic m,
                       input main_state_t s, input logic [31:0] c);
    vec_t v;
    v.rst_n = r; v.op = o; v.mr = m; v.st = s; v.cnt = c;
    vecs.push_back(v);
  endtask

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  // Expected outputs straight from the per-state output table.
  function automatic logic [W-1:0] exp_word(input vec_t v);
    logic [1:0] a_op, sa, sb, rs;
    logic       ad, ir, pu, br, rw, mw, il;
    a_op = 2'b00; sa = 2'b00; sb = 2'b00; rs = 2'b00;
    {ad, ir, pu, br, rw, mw, il} = 7'b0;
    if (!v.rst_n) return '0;
    case (v.st)
      S_FETCH:    begin sb = 2'b10; rs = 2'b10; ir = v.mr; pu = v.mr; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  begin ad = 1'b1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      S_MEMWRITE: begin ad = 1'b1; mw = 1'b1; end
      S_EXECUTER: begin sa = 2'b10; a_op = 2'b10; end
      S_EXECUTEI: begin sa = 2'b10; sb = 2'b01; a_op = 2'b10; end
      S_ALUWB:    begin rw = 1'b1; end
      S_BEQ:      begin sa = 2'b10; a_op = 2'b01; br = 1'b1; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pu = 1'b1; end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      S_TRAP:     begin il = 1'b1; end
`endif
      default: ;
    endcase
    return {4'(v.st), a_op, sa, sb, rs, ad, ir, pu, br, rw, mw, il, v.cnt};
  endfunction

  initial begin
    logic [W-1:0] got, e;

    // Reset held 2 cycles with mem_ready high.
    add_v(0, rnd_op(), 1, S_FETCH, 0);
    add_v(0, rnd_op(), 1, S_FETCH, 0);
    // R-type
    add_v(1, rnd_op(), 1, S_FETCH, 0);
    add_v(1, OP_RTYPE, 1, S_DECODE, 0);
    add_v(1, rnd_op(), 1, S_EXECUTER, 0);
    add_v(1, rnd_op(), 1, S_ALUWB, 0);
    // lw with three wait states in MEMREAD
    add_v(1, rnd_op(), 1, S_FETCH, 1);
    add_v(1, OP_LOAD,  1, S_DECODE, 1);
    add_v(1, OP_LOAD,  1, S_MEMADR, 1);
    add_v(1, rnd_op(), 0, S_MEMREAD, 1);
    add_v(1, rnd_op(), 0, S_MEMREAD, 1);
    add_v(1, rnd_op(), 0, S_MEMREAD, 1);
    add_v(1, rnd_op(), 1, S_MEMREAD, 1);
    add_v(1, rnd_op(), 1, S_MEMWB, 1);
    // fetch wait, then sw with a write wait state
    add_v(1, rnd_op(), 0, S_FETCH, 2);
    add_v(1, rnd_op(), 1, S_FETCH, 2);
    add_v(1, OP_STORE, 1, S_DECODE, 2);
    add_v(1, OP_STORE, 1, S_MEMADR, 2);
    add_v(1, rnd_op(), 0, S_MEMWRITE, 2);
    add_v(1, rnd_op(), 1, S_MEMWRITE, 2);
    // beq
    add_v(1, rnd_op(),  1, S_FETCH, 3);
    add_v(1, OP_BRANCH, 1, S_DECODE, 3);
    add_v(1, rnd_op(),  1, S_BEQ, 3);
    // jal
    add_v(1, rnd_op(), 1, S_FETCH, 4);
    add_v(1, OP_JAL,   1, S_DECODE, 4);
    add_v(1, rnd_op(), 1, S_JAL, 4);
    add_v(1, rnd_op(), 1, S_ALUWB, 4);
    // I-type
    add_v(1, rnd_op(), 1, S_FETCH, 5);
    add_v(1, OP_ITYPE, 1, S_DECODE, 5);
    add_v(1, rnd_op(), 1, S_EXECUTEI, 5);
    add_v(1, rnd_op(), 1, S_ALUWB, 5);
    // reset in the middle of an R-type abandons it and clears the counter
    add_v(1, rnd_op(), 1, S_FETCH, 6);
    add_v(1, OP_RTYPE, 1, S_DECODE, 6);
    add_v(1, rnd_op(), 1, S_EXECUTER, 6);
    add_v(0, rnd_op(), 1, S_FETCH, 0);
    add_v(1, rnd_op(), 1, S_FETCH, 0);
    // illegal opcode
    add_v(1, 7'h7f, 1, S_DECODE, 0);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) add_v(1, rnd_op(), 1, S_TRAP, 0);
    add_v(0, rnd_op(), 1, S_FETCH, 0);
    add_v(1, rnd_op(), 1, S_FETCH, 0);
`else
    add_v(1, rnd_op(), 1, S_FETCH, 1);
    add_v(1, 7'h00,    1, S_DECODE, 1);
    add_v(1, rnd_op(), 1, S_FETCH, 2);
    add_v(1, OP_RTYPE, 1, S_DECODE, 2);
    add_v(1, rnd_op(), 1, S_EXECUTER, 2);
    add_v(1, rnd_op(), 1, S_ALUWB, 2);
    add_v(1, rnd_op(), 1, S_FETCH, 3);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n     = vecs[i].rst_n;
      op        = vecs[i].op;
      mem_ready = vecs[i].mr;
      exp_q.push_back(exp_word(vecs[i]));
      #1;
      got = {4'(dbg_state), alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write,
             pc_update, branch, reg_write, mem_write, illegal_op, instr_retired};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL vec%0d exp_state=%0d got=%h exp=%h", i, vecs[i].st, got, e);
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
